// File: rtl/spi_frame_receiver.sv
// SPI frame receiver: synchronises raw SPI pins, deserialises 16-bit MSB-first
// frames and presents each as a one-cycle valid/error strobe with decoded fields.
module spi_frame_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_pin,
    input  logic       copi_pin,
    input  logic       ncs_pin,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       frame_rw,
    output logic [6:0] frame_addr,
    output logic [7:0] frame_data,
    output logic       frame_addr_ok,
    output logic       busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [6:0] ADDR_LIMIT = 7'(MAX_ADDR);
    localparam logic [4:0] CNT_FULL   = 5'd16;
    localparam logic [4:0] CNT_SAT    = 5'd17;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_pin};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_pin};
        end
    end

    logic sclk_s, copi_s, ncs_s;
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync[SYNC_STAGES-1];

    logic sclk_q, ncs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 1'b0;
            ncs_q  <= 1'b1;
        end else begin
            sclk_q <= sclk_s;
            ncs_q  <= ncs_s;
        end
    end

    logic sclk_rise, ncs_fall, ncs_rise;
    assign sclk_rise = sclk_s & ~sclk_q;
    assign ncs_fall  = ~ncs_s & ncs_q;
    assign ncs_rise  = ncs_s & ~ncs_q;

    state_t      state;
    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic        end_pending;

    // The strobe is issued one cycle after leaving SHIFT; a new ncs_fall in that
    // cycle still clears the shifter, since the strobe reads the pre-clear value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            end_pending   <= 1'b0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            frame_rw      <= 1'b0;
            frame_addr    <= '0;
            frame_data    <= '0;
            frame_addr_ok <= 1'b0;
            busy          <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            end_pending <= 1'b0;

            if (end_pending) begin
                if (bit_cnt == CNT_FULL) begin
                    frame_valid   <= 1'b1;
                    frame_rw      <= shift_reg[15];
                    frame_addr    <= shift_reg[14:8];
                    frame_data    <= shift_reg[7:0];
                    frame_addr_ok <= (shift_reg[14:8] <= ADDR_LIMIT);
                end else begin
                    frame_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        end_pending <= 1'b1;
                    end else if (sclk_rise && !ncs_s) begin
                        shift_reg <= {shift_reg[14:0], copi_s};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: directed SPI frames plus random
// frames, checked against a bit-count/field model of the frame rules.
module tb_spi_frame_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_ADDR    = 4;
    localparam int HALF        = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk_pin = 1'b0;
    logic       copi_pin = 1'b0;
    logic       ncs_pin = 1'b1;
    logic       frame_valid, frame_err, frame_rw, frame_addr_ok, busy;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;

    spi_frame_receiver #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
        .clk(clk), .rst(rst), .sclk_pin(sclk_pin), .copi_pin(copi_pin),
        .ncs_pin(ncs_pin), .frame_valid(frame_valid), .frame_err(frame_err),
        .frame_rw(frame_rw), .frame_addr(frame_addr), .frame_data(frame_data),
        .frame_addr_ok(frame_addr_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: held field values and expected pulse totals
    logic       exp_rw = 1'b0;
    logic [6:0] exp_addr = '0;
    logic [7:0] exp_data = '0;
    logic       exp_ok = 1'b0;
    int exp_vld_total = 0;
    int exp_err_total = 0;

    int vld_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) vld_cnt++;
            if (frame_err) err_cnt++;
            if (frame_valid && frame_err) overlap_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        ncs_pin = 1'b0;
        repeat (HALF) tick();
        check("busy_in_frame", 32'(busy), 32'd1);
    endtask

    task automatic spi_bit(input logic b);
        copi_pin = b;
        repeat (HALF) tick();
        sclk_pin = 1'b1;
        repeat (HALF) tick();
        sclk_pin = 1'b0;
    endtask

    task automatic shift_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) spi_bit(w[i]);
    endtask

    // Raise nCS and check the strobe against the model; eff_bits is the number
    // of sclk rises that should have been counted. b2b drops nCS one cycle later.
    task automatic end_and_check(input string tag, input int eff_bits,
                                 input logic [15:0] w, input bit b2b);
        int  lat;
        bit  seen;
        bit  exp_v;
        lat   = 0;
        seen  = 1'b0;
        exp_v = (eff_bits == 16);
        ncs_pin = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (b2b && lat == 1) ncs_pin = 1'b0;
            if (frame_valid || frame_err) seen = 1'b1;
        end
        if (exp_v) begin
            exp_rw   = w[15];
            exp_addr = w[14:8];
            exp_data = w[7:0];
            exp_ok   = (int'(w[14:8]) <= MAX_ADDR);
            exp_vld_total++;
        end else begin
            exp_err_total++;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(SYNC_STAGES + 2));
        check({tag, "_valid"}, 32'(frame_valid), 32'(exp_v));
        check({tag, "_err"}, 32'(frame_err), 32'(!exp_v));
        check({tag, "_fields"}, {15'd0, frame_rw, frame_addr, frame_data, frame_addr_ok},
              {15'd0, exp_rw, exp_addr, exp_data, exp_ok});
        @(posedge clk);
        @(negedge clk);
        check({tag, "_one_cycle"}, {30'd0, frame_valid, frame_err}, 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'(b2b));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lens [10];
        int n;
        logic [31:0] w;
        lens = '{0, 1, 8, 15, 16, 16, 16, 17, 18, 20};

        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs", {20'd0, frame_valid, frame_err, frame_rw, frame_addr,
              frame_data, frame_addr_ok, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tick();

        start_frame();
        shift_bits(32'h8155, 16);
        end_and_check("write_8155", 16, 16'h8155, 1'b0);
        repeat (4) tick();

        start_frame();
        shift_bits(32'hFFFF, 15);
        end_and_check("short_15", 15, 16'h0, 1'b0);
        repeat (4) tick();

        start_frame();
        shift_bits(32'h05A3, 16);
        end_and_check("read_05a3", 16, 16'h05A3, 1'b0);
        repeat (4) tick();

        start_frame();
        shift_bits(32'h1ABCD, 17);
        end_and_check("long_17", 17, 16'h0, 1'b0);
        repeat (4) tick();

        start_frame();
        end_and_check("zero_len", 0, 16'h0, 1'b0);
        repeat (4) tick();

        // reset mid-frame, then finish the remainder with nCS still low
        start_frame();
        shift_bits(32'h82, 8);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_outputs", {20'd0, frame_valid, frame_err, frame_rw, frame_addr,
              frame_data, frame_addr_ok, busy}, 32'd0);
        exp_rw = 1'b0; exp_addr = '0; exp_data = '0; exp_ok = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) tick();
        check("midreset_rejoin_busy", 32'(busy), 32'd1);
        shift_bits(32'h04, 8);
        end_and_check("midreset_tail", 8, 16'h0, 1'b0);
        repeat (4) tick();

        // 16th sclk rise coincides with nCS rise
        start_frame();
        shift_bits(32'h1234 >> 1, 15);
        copi_pin = 1'b0;
        repeat (HALF) tick();
        sclk_pin = 1'b1;
        end_and_check("collision", 15, 16'h0, 1'b0);
        sclk_pin = 1'b0;
        repeat (4) tick();

        start_frame();
        shift_bits(32'h8003, 16);
        end_and_check("b2b_first", 16, 16'h8003, 1'b1);
        shift_bits(32'h81F0, 16);
        end_and_check("b2b_second", 16, 16'h81F0, 1'b0);
        repeat (4) tick();

        for (int k = 0; k < 16; k++) begin
            n = lens[$urandom_range(9, 0)];
            w = $urandom;
            start_frame();
            shift_bits(w, n);
            end_and_check("random", n, w[15:0], 1'b0);
            repeat ($urandom_range(6, 2)) tick();
        end

        repeat (10) tick();
        check("total_valid_pulses", 32'(vld_cnt), 32'(exp_vld_total));
        check("total_err_pulses", 32'(err_cnt), 32'(exp_err_total));
        check("valid_err_overlap", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
- Upstream front end of the SPI control path. Sits between the raw SPI pins (SCLK, COPI, nCS on ui_in) and the register bank that drives the PWM peripheral's enable and duty-cycle registers.
- Synchronises the asynchronous SPI pins into the system clock domain and detects edges on them.
- Deserialises 16-bit frames, MSB first.
- Presents each complete frame as a one-cycle strobe carrying rw/addr/data fields, or flags it as malformed.

Parameters:
- SYNC_STAGES, 2: flip-flop stages per pin synchroniser; legal range 2..3.
- MAX_ADDR, 4: highest legal register address; used only for frame_addr_ok.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sclk_pin  input  1  raw SPI clock, asynchronous to clk; mode 0
- copi_pin  input  1  raw SPI data in, asynchronous
- ncs_pin  input  1  raw chip select, active-low, asynchronous
- frame_valid  output  1  one-cycle strobe; a well-formed 16-bit frame has completed
- frame_err  output  1  one-cycle strobe; frame ended with bit count other than 16
- frame_rw  output  1  bit 15 of the frame; 1 = write, 0 = read
- frame_addr  output  7  bits 14:8 of the frame
- frame_data  output  8  bits 7:0 of the frame
- frame_addr_ok  output  1  1 when frame_addr <= MAX_ADDR
- busy  output  1  high while a frame is being shifted in

Behaviour:
- Reset: rst is sampled on the rising edge of clk only. On reset:
  - synchroniser chains go to sclk=0, copi=0, ncs=1;
  - edge-history flops match those values;
  - FSM goes to IDLE; shift register and bit counter go to 0;
  - all outputs go to 0.
- Synchronisers: each pin passes through SYNC_STAGES flops. Only the last stage is used downstream.
- Edge detection: a one-flop history of each synced signal gives:
  - sclk_rise = synced sclk goes 0→1;
  - ncs_fall = synced ncs goes 1→0;
  - ncs_rise = synced ncs goes 0→1.
- FSM has two states, IDLE and SHIFT:
  - IDLE: busy=0. On ncs_fall, clear the shift register and bit counter, then go to SHIFT. All sclk edges are ignored in IDLE.
  - SHIFT: busy=1. On sclk_rise while synced ncs=0, shift the synced copi value into the LSB (MSB-first frame) and increment the bit counter. The 5-bit counter saturates at 17.
  - SHIFT on ncs_rise: go to IDLE. In the next cycle:
    - if count == 16, pulse frame_valid and load frame_rw, frame_addr, frame_data and frame_addr_ok from the shift register;
    - otherwise pulse frame_err and leave the field outputs unchanged.
- Simultaneous sclk_rise and ncs_rise in the same cycle: the sclk edge is discarded and ncs_rise takes effect.
- frame_valid and frame_err are never high together. Each is high for exactly one clk cycle per frame.
- Field outputs hold their values until the next frame_valid or reset.
- Latency: the strobe rises exactly SYNC_STAGES+2 clk cycles after ncs_pin rises, given ncs_pin is stable at least one clk period before that edge.
- Over-length frames (17 or more sclk edges): frame_err, and the saturated counter never wraps back to 16.
- Zero-length frames (nCS pulse with no sclk edges): frame_err.
- Reset mid-frame: the frame is abandoned and no strobe is produced. If ncs_pin is still low when rst releases, the synced ncs falls after the chain flushes. This is treated as ncs_fall, and the remaining partial frame ends in frame_err.
- A stray ncs_rise in IDLE (for example, right after reset) produces no strobe.
- Back-to-back frames: an ncs_fall arriving in the same cycle as the strobe is accepted. The next frame shifts normally.
- Timing constraint (not checked by the block): SCLK high and low phases must each last at least SYNC_STAGES+1 clk periods.

Test Plan:
- Write frame: nCS low, shift 0x8155 MSB-first, nCS high → one frame_valid pulse SYNC_STAGES+2 cycles after nCS rises. Fields: rw=1, addr=0x01, data=0x55, addr_ok=1, frame_err=0.
- Read frame with out-of-range address (MAX_ADDR=4): shift 0x05A3 → frame_valid with rw=0, addr=0x05, data=0xA3, addr_ok=0.
- Malformed lengths:
  - 15 bits of 0xFFFF → frame_err pulse, no frame_valid, fields keep the previous 0x8155 values;
  - 17 bits → frame_err;
  - nCS pulse with no SCLK → frame_err.
- Reset mid-frame: assert rst after 8 bits of 0x8204 → busy=0 and all outputs 0. Release rst with nCS still low, clock 8 more bits, raise nCS → frame_err only.
- Edge collision: the 16th SCLK rise lands in the same synced cycle as the nCS rise → edge discarded, count=15, frame_err.
- Back-to-back frames: 0x8003 then 0x81F0, with the second nCS falling on the first frame's strobe cycle → two frame_valid pulses, fields 0x8003 then 0x81F0, no errors.
